// File: rtl/pad_io_ctrl.sv
// Core-side controller for a bank of GF22 GPIO pads: power/retention sequencing,
// gated output drive, and synchronised, glitch-filtered input with edge pulses.
module pad_io_ctrl #(
  parameter int unsigned NUM_PADS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned SEQ_DLY     = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pwr_en_i,
  input  logic                ret_req_i,
  output logic                ready_o,
  output logic [2:0]          state_o,
  output logic                pad_iopwrok_o,
  output logic                pad_pwrok_o,
  output logic                pad_retc_o,
  input  logic [NUM_PADS-1:0] out_i,
  input  logic [NUM_PADS-1:0] oe_i,
  output logic [NUM_PADS-1:0] pad_i_o,
  output logic [NUM_PADS-1:0] pad_oen_o,
  input  logic [NUM_PADS-1:0] pad_o_i,
  output logic [NUM_PADS-1:0] in_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o
);

  localparam int unsigned CW = $clog2(SEQ_DLY + 1);
  localparam int unsigned FW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] SEQ_LAST  = CW'(SEQ_DLY - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_IO_UP   = 3'd1;
  localparam logic [2:0] S_CORE_UP = 3'd2;
  localparam logic [2:0] S_ACTIVE  = 3'd3;
  localparam logic [2:0] S_RET     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          iopwrok_q, iopwrok_d;
  logic          pwrok_q, pwrok_d;
  logic          retc_q, retc_d;
  logic          ready_q, ready_d;
  logic          run_d;

  logic [NUM_PADS-1:0] pad_i_q, pad_i_d;
  logic [NUM_PADS-1:0] oen_q, oen_d;

  logic [NUM_PADS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NUM_PADS-1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [NUM_PADS-1:0] in_q, in_d;
  logic [NUM_PADS-1:0] rise_q, rise_d;
  logic [NUM_PADS-1:0] fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (pwr_en_i) begin
          state_d = S_IO_UP;
          cnt_d   = '0;
        end
      end
      S_IO_UP: begin
        if (!pwr_en_i) begin
          state_d = S_OFF;
        end else if (cnt_q == SEQ_LAST) begin
          state_d = S_CORE_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CORE_UP: begin
        if (!pwr_en_i) begin
          state_d = S_OFF;
        end else if (cnt_q == SEQ_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (!pwr_en_i)     state_d = S_OFF;
        else if (ret_req_i) state_d = S_RET;
      end
      S_RET: begin
        if (!pwr_en_i)      state_d = S_OFF;
        else if (!ret_req_i) state_d = S_ACTIVE;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Status flops are loaded from the next state so they move on the same edge as state_o.
  always_comb begin
    run_d     = (state_d == S_ACTIVE) || (state_d == S_RET);
    iopwrok_d = (state_d != S_OFF);
    pwrok_d   = (state_d != S_OFF) && (state_d != S_IO_UP);
    ready_d   = (state_d == S_ACTIVE);
    retc_d    = (state_d == S_RET);
  end

  // Tracking keys off the current state, so re-entry to ACTIVE resumes a cycle later.
  always_comb begin
    pad_i_d = pad_i_q;
    oen_d   = oen_q;
    if (!run_d) begin
      pad_i_d = '0;
      oen_d   = '1;
    end else if (state_q == S_ACTIVE) begin
      pad_i_d = out_i;
      oen_d   = ~oe_i;
    end
  end

  always_comb begin
    sync_d = sync_q;
    fcnt_d = fcnt_q;
    in_d   = in_q;
    rise_d = '0;
    fall_d = '0;
    if (!run_d) begin
      sync_d = '0;
      fcnt_d = '0;
      in_d   = '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        sync_d[p] = {sync_q[p][SYNC_STAGES-2:0], pad_o_i[p]};
        if (sync_q[p][SYNC_STAGES-1] == in_q[p]) begin
          fcnt_d[p] = '0;
        end else if (fcnt_q[p] == FILT_LAST) begin
          fcnt_d[p] = '0;
          in_d[p]   = sync_q[p][SYNC_STAGES-1];
          rise_d[p] = sync_q[p][SYNC_STAGES-1];
          fall_d[p] = ~sync_q[p][SYNC_STAGES-1];
        end else begin
          fcnt_d[p] = fcnt_q[p] + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      iopwrok_q <= 1'b0;
      pwrok_q   <= 1'b0;
      retc_q    <= 1'b0;
      ready_q   <= 1'b0;
      pad_i_q   <= '0;
      oen_q     <= '1;
      sync_q    <= '0;
      fcnt_q    <= '0;
      in_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iopwrok_q <= iopwrok_d;
      pwrok_q   <= pwrok_d;
      retc_q    <= retc_d;
      ready_q   <= ready_d;
      pad_i_q   <= pad_i_d;
      oen_q     <= oen_d;
      sync_q    <= sync_d;
      fcnt_q    <= fcnt_d;
      in_q      <= in_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign state_o       = state_q;
  assign ready_o       = ready_q;
  assign pad_iopwrok_o = iopwrok_q;
  assign pad_pwrok_o   = pwrok_q;
  assign pad_retc_o    = retc_q;
  assign pad_i_o       = pad_i_q;
  assign pad_oen_o     = oen_q;
  assign in_o          = in_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Self-checking bench for pad_io_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_pad_io_ctrl;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int FC = 4;
  localparam int SD = 16;
  localparam int D  = SS + FC;

  logic         clk, rst_n, pwr_en, ret_req;
  logic [N-1:0] out_d, oe_d, pad_o;
  logic         ready, iopwrok, pwrok, retc;
  logic [2:0]   state;
  logic [N-1:0] pad_i, pad_oen, in_v, rise, fall;

  pad_io_ctrl #(.NUM_PADS(N), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .SEQ_DLY(SD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pwr_en_i(pwr_en), .ret_req_i(ret_req),
    .ready_o(ready), .state_o(state), .pad_iopwrok_o(iopwrok), .pad_pwrok_o(pwrok),
    .pad_retc_o(retc), .out_i(out_d), .oe_i(oe_d), .pad_i_o(pad_i), .pad_oen_o(pad_oen),
    .pad_o_i(pad_o), .in_o(in_v), .rise_o(rise), .fall_o(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 'up' is edges since the power-up request was accepted (-1 = off,
  // saturating once ACTIVE is reached); hist[k] holds the raw pad byte sampled k+1 edges ago.
  int           up;
  bit           mret;
  logic [N-1:0] m_pi, m_oen, m_in, m_rise, m_fall;
  logic [N-1:0] hist [D];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_state();
    if (up < 0)       return 3'd0;
    if (up < SD)      return 3'd1;
    if (up < 2 * SD)  return 3'd2;
    return mret ? 3'd4 : 3'd3;
  endfunction

  task automatic model_reset();
    up = -1; mret = 0; m_pi = '0; m_oen = '1; m_in = '0; m_rise = '0; m_fall = '0;
    for (int k = 0; k < D; k++) hist[k] = '0;
  endtask

  task automatic model_step();
    bit old_active, old_run, new_run, all_diff;
    old_run    = (up >= 2 * SD);
    old_active = old_run && !mret;
    mret = pwr_en && old_run && ret_req;
    if (!pwr_en)          up = -1;
    else if (up < 0)      up = 0;
    else if (up < 2 * SD) up = up + 1;
    new_run = (up >= 2 * SD);
    m_rise = '0; m_fall = '0;
    if (!new_run) begin
      m_pi = '0; m_oen = '1; m_in = '0;
      for (int k = 0; k < D; k++) hist[k] = '0;
    end else begin
      if (old_active) begin
        m_pi = out_d; m_oen = ~oe_d;
      end
      for (int p = 0; p < N; p++) begin
        all_diff = 1;
        for (int k = SS - 1; k <= SS + FC - 2; k++)
          if (hist[k][p] == m_in[p]) all_diff = 0;
        if (all_diff) begin
          m_in[p] = ~m_in[p];
          m_rise[p] = m_in[p];
          m_fall[p] = ~m_in[p];
        end
      end
      for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pad_o;
    end
  endtask

  task automatic check_model();
    chk("state", 32'(state), 32'(m_state()));
    chk("iopwrok", 32'(iopwrok), 32'(up >= 0));
    chk("pwrok", 32'(pwrok), 32'(up >= SD));
    chk("ready", 32'(ready), 32'((up >= 2 * SD) && !mret));
    chk("retc", 32'(retc), 32'(mret));
    chk("pad_i", 32'(pad_i), 32'(m_pi));
    chk("pad_oen", 32'(pad_oen), 32'(m_oen));
    chk("in_o", 32'(in_v), 32'(m_in));
    chk("rise_o", 32'(rise), 32'(m_rise));
    chk("fall_o", 32'(fall), 32'(m_fall));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic power_up();
    pwr_en = 1'b1;
    ret_req = 1'b0;
    repeat (2 * SD + 1) tick();
  endtask

  typedef struct {
    logic pwr, ret;
    logic [N-1:0] out, oe, e_pi, e_oen;
    logic e_ready, e_retc;
    logic [2:0] e_state;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h0F, 8'hA5, 8'hF0, 1'b1, 1'b0, 3'd3};
    tbl[1] = '{1'b1, 1'b1, 8'hA5, 8'h0F, 8'hA5, 8'hF0, 1'b0, 1'b1, 3'd4};
    tbl[2] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'hA5, 8'hF0, 1'b0, 1'b1, 3'd4};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'hA5, 8'hF0, 1'b1, 1'b0, 3'd3};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 3'd3};
    tbl[5] = '{1'b0, 1'b1, 8'h3C, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0};

    rst_n = 1'b0; pwr_en = 1'b0; ret_req = 1'b0;
    out_d = '0; oe_d = '0; pad_o = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    // Power-up sequence timing
    pwr_en = 1'b1;
    out_d = 8'h5C; oe_d = 8'hFF;
    for (int k = 1; k <= 2 * SD + 1; k++) begin
      tick();
      if (k == 1) chk("pu_state_io_up", 32'(state), 32'd1);
      if (k == 1) chk("pu_iopwrok", 32'(iopwrok), 32'd1);
      if (k == SD) chk("pu_pwrok_early", 32'(pwrok), 32'd0);
      if (k == SD + 1) chk("pu_pwrok", 32'(pwrok), 32'd1);
      if (k == SD + 1) chk("pu_state_core_up", 32'(state), 32'd2);
      if (k == 2 * SD) chk("pu_ready_early", 32'(ready), 32'd0);
      if (k == 2 * SD + 1) chk("pu_ready", 32'(ready), 32'd1);
      if (k <= 2 * SD) chk("pu_oen", 32'(pad_oen), 32'hFF);
    end

    // Output drive, retention freeze, re-entry and abort priority
    for (int i = 0; i < 6; i++) begin
      pwr_en = tbl[i].pwr; ret_req = tbl[i].ret;
      out_d = tbl[i].out; oe_d = tbl[i].oe;
      tick();
      chk($sformatf("tbl%0d_pad_i", i), 32'(pad_i), 32'(tbl[i].e_pi));
      chk($sformatf("tbl%0d_oen", i), 32'(pad_oen), 32'(tbl[i].e_oen));
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_retc", i), 32'(retc), 32'(tbl[i].e_retc));
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
    end

    // Glitch filter: short pulse rejected, long pulse accepted with exact latency
    power_up();
    for (int k = 1; k <= 12; k++) begin
      pad_o[0] = (k <= 3);
      tick();
      chk("glitch_in0", 32'(in_v[0]), 32'd0);
      chk("glitch_rise0", 32'(rise[0]), 32'd0);
    end
    for (int k = 1; k <= 17; k++) begin
      pad_o[0] = (k <= 10);
      tick();
      chk("long_in0", 32'(in_v[0]), 32'((k >= 6) && (k < 16)));
      chk("long_rise0", 32'(rise[0]), 32'(k == 6));
      chk("long_fall0", 32'(fall[0]), 32'(k == 16));
    end

    // Wake detection in retention with frozen pad outputs
    out_d = 8'h5A; oe_d = 8'h33;
    tick();
    ret_req = 1'b1;
    tick();
    pad_o[3] = 1'b1; out_d = 8'hFF; oe_d = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("wake_rise3", 32'(rise[3]), 32'(k == 6));
      chk("wake_pad_i", 32'(pad_i), 32'h5A);
      chk("wake_oen", 32'(pad_oen), 32'hCC);
      chk("wake_retc", 32'(retc), 32'd1);
    end
    ret_req = 1'b0; pad_o = '0;
    repeat (8) tick();

    // Abort during IO_UP
    pwr_en = 1'b0;
    tick();
    pwr_en = 1'b1;
    repeat (5) tick();
    pwr_en = 1'b0;
    tick();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_iopwrok", 32'(iopwrok), 32'd0);
    for (int k = 0; k < 2 * SD; k++) begin
      tick();
      if (pwrok !== 1'b0) chk("abort_pwrok", 32'(pwrok), 32'd0);
    end
    chk("abort_pwrok_end", 32'(pwrok), 32'd0);

    // Randomized traffic
    pwr_en = 1'b1; ret_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (pwr_en && $urandom_range(0, 399) == 0) pwr_en = 1'b0;
      else if (!pwr_en && $urandom_range(0, 3) == 0) pwr_en = 1'b1;
      if ($urandom_range(0, 39) == 0) ret_req = ~ret_req;
      out_d = N'($urandom); oe_d = N'($urandom);
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 5) == 0) pad_o[p] = ~pad_o[p];
      tick();
    end

    // Asynchronous reset while active with all inputs high
    pwr_en = 1'b0; ret_req = 1'b0; pad_o = '0;
    tick();
    power_up();
    pad_o = '1;
    repeat (8) tick();
    chk("pre_reset_in", 32'(in_v), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("rst_oen", 32'(pad_oen), 32'hFF);
    chk("rst_pad_i", 32'(pad_i), 32'h00);
    chk("rst_iopwrok", 32'(iopwrok), 32'd0);
    chk("rst_pwrok", 32'(pwrok), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in", 32'(in_v), 32'h00);
    chk("rst_fall", 32'(fall), 32'h00);
    chk("rst_rise", 32'(rise), 32'h00);
    model_reset();
    pwr_en = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
